// File: rtl/serial_adder_pkg.sv
// Package wrapping the shared serial adder definitions.
package serial_adder_pkg;
  `include "serial_adder_defs.vh"

  typedef logic [1:0] sa_state_t;
endpackage

// File: rtl/serial_adder_defs.vh
// Shared state encodings and default operand width for the serial adder.
`ifndef SERIAL_ADDER_DEFS_VH
`define SERIAL_ADDER_DEFS_VH
localparam logic [1:0] ST_IDLE = 2'd0;
localparam logic [1:0] ST_RUN  = 2'd1;
localparam logic [1:0] ST_DONE = 2'd2;
localparam int SA_WIDTH_DEFAULT = 8;
`endif

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder used as the serial adder's datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a single full-adder cell.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sa_state_t        state_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  fa_cell u_fa (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (Start) begin
            // Subtract is A + ~B + 1, so Cin is replaced by a forced carry.
            a_reg     <= A;
            b_reg     <= B ^ {WIDTH{Sub}};
            carry_reg <= Sub | Cin;
            cnt_reg   <= '0;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_reg   <= (sum_reg >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          carry_reg <= fa_co;
          if (last_bit) begin
            // carry_reg here is the carry into the MSB.
            cout_reg  <= fa_co;
            ovf_reg   <= carry_reg ^ fa_co;
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign Busy = (state_reg == ST_RUN);
  assign Done = (state_reg == ST_DONE);
  assign Sum  = sum_reg;
  assign Cout = cout_reg;
  assign Ovf  = ovf_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;
  logic       clk;
  logic       rst_n;
  logic       start8, cin8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, sub1, busy1, done1, cout1, ovf1;
  logic [0:0] a1, b1, sum1;

  int vectors;
  int miscompares;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Rst_n(rst_n), .Start(start8), .A(a8), .B(b8), .Cin(cin8), .Sub(sub8),
    .Busy(busy8), .Done(done8), .Sum(sum8), .Cout(cout8), .Ovf(ovf8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .Clk(clk), .Rst_n(rst_n), .Start(start1), .A(a1), .B(b1), .Cin(cin1), .Sub(sub1),
    .Busy(busy1), .Done(done1), .Sum(sum1), .Cout(cout1), .Ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic s,
                     input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    int bcyc;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
    @(posedge clk);
    lat = 1;
    bcyc = 0;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~c; sub8 = ~s;
    while (!done8 && lat < 40) begin
      if (busy8) bcyc++;
      @(negedge clk);
      lat++;
    end
    $display("%s: a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d busy=%0d",
             tag, a, b, c, s, sum8, cout8, ovf8, lat, bcyc);
    check({tag, "_lat"}, lat, 9);
    check({tag, "_busycyc"}, bcyc, 8);
    check({tag, "_busy_in_done"}, busy8, 0);
    check({tag, "_sum"}, sum8, es);
    check({tag, "_cout"}, cout8, ec);
    check({tag, "_ovf"}, ovf8, eo);
    @(negedge clk);
    check({tag, "_done_once"}, done8, 0);
    check({tag, "_sum_hold"}, sum8, es);
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    int lat;
    logic [1:0] exp;
    string tag;
    exp = 2'(a) + 2'(b) + 2'(c);
    tag = $sformatf("w1_%0d%0d%0d", a, b, c);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; sub1 = 1'b0; start1 = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start1 = 1'b0;
    a1 = ~a; b1 = ~b; cin1 = ~c;
    while (!done1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    $display("%s: sum=%0d cout=%0d ovf=%0d lat=%0d", tag, sum1, cout1, ovf1, lat);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_sum"}, sum1, exp[0]);
    check({tag, "_cout"}, cout1, exp[1]);
    check({tag, "_ovf"}, ovf1, c ^ exp[1]);
  endtask

  initial begin
    int lat;
    int dcnt;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_sum", sum8, 0);
    check("rst_cout", cout8, 0);
    check("rst_ovf", ovf8, 0);
    check("rst_w1_all", {busy1, done1, sum1, cout1, ovf1}, 0);
    rst_n = 1'b1;

    op8("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("add_10_20_c", 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
    op8("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
    op8("sub_05_07_c0", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);

    // Start pulsed mid-RUN, then held through DONE.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk); a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk); start8 = 1'b1;
    lat = 0;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    $display("ignore_start: sum=%h cout=%0d ovf=%0d", sum8, cout8, ovf8);
    check("ign_done", done8, 1);
    check("ign_sum", sum8, 8'h46);
    check("ign_cout", cout8, 0);
    check("ign_ovf", ovf8, 0);
    @(negedge clk);
    check("ign_done_once", done8, 0);
    check("ign_no_accept_in_done", busy8, 0);
    check("ign_sum_hold", sum8, 8'h46);
    @(negedge clk);
    check("ign_accept_in_idle", busy8, 1);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    $display("reaccept: sum=%h cout=%0d ovf=%0d", sum8, cout8, ovf8);
    check("reacc_sum", sum8, 8'hFE);
    check("reacc_cout", cout8, 1);
    check("reacc_ovf", ovf8, 0);

    // Reset asserted for one edge during the 4th RUN cycle.
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    $display("abort: busy=%0d done=%0d sum=%h cout=%0d ovf=%0d", busy8, done8, sum8, cout8, ovf8);
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_sum", sum8, 0);
    check("abort_cout", cout8, 0);
    check("abort_ovf", ovf8, 0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) dcnt++;
    end
    check("abort_no_done", dcnt, 0);

    for (int v = 0; v < 8; v++) begin
      logic [2:0] bits;
      bits = 3'(v);
      op1(bits[2], bits[1], bits[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
